// File: rtl/mul_pkg.sv
// Shared types and sizing for the multiplier issue slice.
// WDOG_MAX is the saturated value of the WIDTH_LOG+1 bit cycle counter.
package mul_pkg;
  localparam int WIDTH_LOG = 5;
  localparam int WIDTH     = 1 << WIDTH_LOG;
  localparam int OUT_WIDTH = 2 * WIDTH;
  localparam int CNT_W     = WIDTH_LOG + 1;
  localparam int LAT_MAX   = WIDTH + 2;
  localparam int WDOG_MAX  = (1 << CNT_W) - 1;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    WAIT,
    PAD,
    HOLD
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } mul_req_t;
endpackage

// File: rtl/mul_issue_if.sv
// Request, multiplier-launch and response signals of mul_issue.
// master drives the requests and the multiplier model; slave is the issuer.
interface mul_issue_if
  import mul_pkg::*;
;
  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic                 mul_in_valid;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mul_out_valid;
  logic [OUT_WIDTH-1:0] mul_o;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_WIDTH-1:0] rsp_o;
  logic                 busy;
  logic                 err;

  modport master (
    output req_valid, req_a, req_b,
    output mul_out_valid, mul_o, rsp_ready,
    input  req_ready, mul_in_valid, mul_a, mul_b,
    input  rsp_valid, rsp_o, busy, err
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  mul_out_valid, mul_o, rsp_ready,
    output req_ready, mul_in_valid, mul_a, mul_b,
    output rsp_valid, rsp_o, busy, err
  );
endinterface

// File: rtl/mul_req_fifo.sv
// Four-entry operand FIFO; caller guarantees no push when full
// and no pop when empty.
module mul_req_fifo
  import mul_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  mul_req_t din,
  output mul_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int DEPTH = 4;

  mul_req_t   mem [DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  assign full  = count == 3'(DEPTH);
  assign empty = count == 3'd0;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mul_issue.sv
// Issues buffered operand pairs to a shift-add multiplier, one at a time.
// MUL_ISSUE_CONST_TIME_EN pads every response to LAT_MAX+1 cycles.
module mul_issue
  import mul_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  mul_issue_if.slave bus
);
  state_e               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [OUT_WIDTH-1:0] rsp_q, rsp_n;
  logic                 err_q, err_n;
  logic                 push, pop;
  logic                 full, empty;
  logic                 lat_end;
  mul_req_t             req_in, head;

  assign req_in = '{a: bus.req_a, b: bus.req_b};
  assign push   = bus.req_valid && !full;

  mul_req_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (req_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // cnt trails the issue cycle by one, so this is issue + LAT_MAX
  assign lat_end = cnt >= CNT_W'(LAT_MAX - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
      cnt   <= '0;
      rsp_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rsp_q <= rsp_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rsp_n   = rsp_q;
    err_n   = err_q;
    pop     = 1'b0;
    if (cnt != '1) cnt_n = cnt + 1'b1;
    unique case (state)
      SYNC: begin
        if (bus.mul_out_valid || cnt == CNT_W'(LAT_MAX))
          state_n = IDLE;
      end
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mul_out_valid) begin
          rsp_n = bus.mul_o;
`ifdef MUL_ISSUE_CONST_TIME_EN
          state_n = lat_end ? HOLD : PAD;
`else
          state_n = HOLD;
`endif
        end else if (cnt == '1) begin
          err_n   = 1'b1;
          rsp_n   = '0;
          state_n = HOLD;
        end
      end
      PAD: begin
        if (lat_end) state_n = HOLD;
      end
      HOLD: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = SYNC;
    endcase
  end

  assign bus.req_ready    = !full;
  assign bus.mul_in_valid = pop;
  assign bus.mul_a        = pop ? head.a : '0;
  assign bus.mul_b        = pop ? head.b : '0;
  assign bus.rsp_valid    = state == HOLD;
  assign bus.rsp_o        = rsp_q;
  assign bus.busy         = state != IDLE || !empty;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_mul_issue.sv
// Randomised bench for mul_issue against a cycle-count reference model.
// Define MUL_ISSUE_CONST_TIME_EN for both RTL and bench to test padding.
module tb_mul_issue;
  import mul_pkg::*;

`ifdef MUL_ISSUE_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mul_issue_if bus();

  mul_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] mq[$];
  logic [63:0] dq[$];
  bit          pend, wd, mul_busy, exp_err;
  int          free_at, rsp_cyc, issue_cyc, mul_due, stray_at;
  logic [63:0] exp_rsp, mul_val;
  bit          rnd_en, stray_en, drop_next;
  int          rdy_mode;

  int          act_iss[$];
  logic [63:0] act_ops[$];
  int          act_lat[$];
  logic [63:0] act_rsp[$];
  int          act_last_iss;
  int          acc;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // multiplier model: 2 cycles for a zero operand, else 3 + msb index of b
  function automatic int mlat(logic [31:0] a, logic [31:0] b);
    int m = 0;
    if (a == 0 || b == 0) return 2;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    return 3 + m;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h1;
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  task automatic clear_logs();
    act_iss.delete();
    act_ops.delete();
    act_lat.delete();
    act_rsp.delete();
  endtask

  task automatic step();
    bit          e_iss, e_rv, e_rdy, e_busy, sv, from_dq;
    logic [63:0] r;
    logic [31:0] a, b;
    int          l;
    if (pend && wd && cyc >= rsp_cyc) exp_err = 1'b1;
    e_rdy  = mq.size() < 4;
    e_iss  = !pend && cyc >= free_at && mq.size() > 0;
    e_rv   = pend && cyc >= rsp_cyc;
    e_busy = cyc < free_at || pend || mq.size() > 0;
    chk("req_ready", bus.req_ready, e_rdy);
    chk("mul_in_valid", bus.mul_in_valid, e_iss);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("busy", bus.busy, e_busy);
    chk("err", bus.err, exp_err);
    if (e_rv) chk("rsp_o", bus.rsp_o, exp_rsp);
    if (bus.mul_in_valid === 1'b1) begin
      act_iss.push_back(cyc);
      act_ops.push_back({bus.mul_a, bus.mul_b});
      act_last_iss = cyc;
    end
    if (e_iss) begin
      r = mq.pop_front();
      a = r[63:32];
      b = r[31:0];
      chk("mul_a", bus.mul_a, a);
      chk("mul_b", bus.mul_b, b);
      pend = 1'b1;
      issue_cyc = cyc;
      if (drop_next) begin
        drop_next = 1'b0;
        wd = 1'b1;
        rsp_cyc = cyc + WDOG_MAX + 2;
        exp_rsp = '0;
      end else begin
        wd = 1'b0;
        l = mlat(a, b);
        mul_busy = 1'b1;
        mul_due = cyc + l;
        mul_val = {32'b0, a} * {32'b0, b};
        exp_rsp = mul_val;
        rsp_cyc = CT ? cyc + LAT_MAX + 1 : cyc + l + 1;
      end
    end
    sv = (stray_at == cyc) ||
         (stray_en && !mul_busy && !(pend && wd) && cyc >= free_at &&
          $urandom_range(0, 9) == 0);
    if (mul_busy && cyc == mul_due) begin
      bus.mul_out_valid = 1'b1;
      bus.mul_o = mul_val;
      mul_busy = 1'b0;
    end else if (sv) begin
      bus.mul_out_valid = 1'b1;
      bus.mul_o = {$urandom, $urandom};
      if (cyc < free_at) free_at = cyc + 1;
    end else begin
      bus.mul_out_valid = 1'b0;
      bus.mul_o = {$urandom, $urandom};
    end
    from_dq = 1'b0;
    if (dq.size() > 0) begin
      from_dq = 1'b1;
      bus.req_valid = 1'b1;
      {bus.req_a, bus.req_b} = dq[0];
    end else if (rnd_en && $urandom_range(0, 2) == 0) begin
      bus.req_valid = 1'b1;
      bus.req_a = rnd_op();
      bus.req_b = rnd_op();
    end else begin
      bus.req_valid = 1'b0;
      bus.req_a = $urandom;
      bus.req_b = $urandom;
    end
    if (bus.req_valid && bus.req_ready === 1'b1) acc++;
    if (bus.req_valid && e_rdy) begin
      mq.push_back({bus.req_a, bus.req_b});
      if (from_dq) void'(dq.pop_front());
    end
    case (rdy_mode)
      0: bus.rsp_ready = 1'b0;
      1: bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = 1'($urandom_range(0, 1));
    endcase
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
      act_lat.push_back(cyc - act_last_iss);
      act_rsp.push_back(bus.rsp_o);
    end
    if (e_rv && bus.rsp_ready) begin
      pend = 1'b0;
      wd = 1'b0;
      free_at = cyc + 1;
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      step();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.mul_out_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    repeat (2) begin
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_mul_in_valid", bus.mul_in_valid, 0);
      chk("rst_mul_a", bus.mul_a, 0);
      chk("rst_mul_b", bus.mul_b, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_o", bus.rsp_o, 0);
      chk("rst_busy", bus.busy, 1);
      chk("rst_err", bus.err, 0);
      @(posedge clk);
      #1;
    end
    mq.delete();
    pend = 1'b0;
    wd = 1'b0;
    mul_busy = 1'b0;
    exp_err = 1'b0;
    free_at = LAT_MAX + 1;
    stray_at = -1;
    cyc = 0;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.mul_out_valid = 1'b0;
    bus.mul_o = '0;
    bus.rsp_ready = 1'b0;
    rnd_en = 1'b0;
    stray_en = 1'b0;
    drop_next = 1'b0;
    rdy_mode = 0;
    stray_at = -1;

    // single request, response held until accepted
    clear_logs();
    dq.push_back({32'd3, 32'd5});
    do_reset();
    run(60);
    rdy_mode = 1;
    run(5);
    if (act_iss.size() == 1 && act_rsp.size() == 1) begin
      chk("first_issue_cyc", 64'(act_iss[0]), 64'd35);
      chk("first_issue_ops", act_ops[0], {32'd3, 32'd5});
      chk("first_rsp", act_rsp[0], 64'd15);
    end else begin
      chk("first_txn_count", 64'(act_iss.size() + act_rsp.size()), 64'd2);
    end

    // five back-to-back pushes with the response blocked
    clear_logs();
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) dq.push_back({32'(i + 2), 32'(i + 11)});
    acc = 0;
    do_reset();
    run(4);
    chk("accepted_of_5", 64'(acc), 64'd4);
    run(100);
    chk("issues_while_blocked", 64'(act_iss.size()), 64'd1);
    rdy_mode = 1;
    run(300);
    chk("drain_rsp_count", 64'(act_rsp.size()), 64'd5);

    // latency for shortest and longest operand pairs
    clear_logs();
    dq.push_back({32'd0, 32'd7});
    dq.push_back({32'd1, 32'h8000_0000});
    run(120);
    if (act_lat.size() == 2) begin
      chk("lat_zero_op", 64'(act_lat[0]), CT ? 64'd35 : 64'd3);
      chk("lat_msb_op", 64'(act_lat[1]), 64'd35);
      chk("rsp_msb_op", act_rsp[1], 64'h0000_0000_8000_0000);
    end else begin
      chk("lat_count", 64'(act_lat.size()), 64'd2);
    end

    // multiplier never answers
    clear_logs();
    drop_next = 1'b1;
    dq.push_back({32'd6, 32'd7});
    run(100);
    chk("wdog_err", bus.err, 1);
    if (act_lat.size() == 1) begin
      chk("wdog_lat", 64'(act_lat[0]), 64'd65);
      chk("wdog_rsp", act_rsp[0], 64'd0);
    end else begin
      chk("wdog_count", 64'(act_lat.size()), 64'd1);
    end

    // reset while waiting, stray completion shortly after release
    clear_logs();
    dq.push_back({32'd9, 32'd9});
    do_reset();
    run(40);
    clear_logs();
    dq.push_back({32'd2, 32'd3});
    do_reset();
    stray_at = 3;
    run(50);
    if (act_iss.size() == 1 && act_rsp.size() == 1) begin
      chk("resync_issue_cyc", 64'(act_iss[0]), 64'd4);
      chk("resync_rsp", act_rsp[0], 64'd6);
    end else begin
      chk("resync_count", 64'(act_iss.size() + act_rsp.size()), 64'd2);
    end

    // all-ones operands
    clear_logs();
    dq.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    run(60);
    chk("ones_err", bus.err, 0);
    if (act_rsp.size() == 1)
      chk("ones_rsp", act_rsp[0], 64'hFFFF_FFFE_0000_0001);
    else
      chk("ones_count", 64'(act_rsp.size()), 64'd1);

    // random traffic, random backpressure, stray completions
    rnd_en = 1'b1;
    stray_en = 1'b1;
    rdy_mode = 2;
    run(2500);
    rnd_en = 1'b0;
    stray_en = 1'b0;
    rdy_mode = 1;
    run(300);
    chk("final_idle_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
